// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fir_pkg
// Purpose  : Shared constants and types for the 3-way unfolded FIR output
//            path. Holds the default sample width, the lane count, the
//            lane-triple and lane-index types, and the lane-sequencing helper.
// Revision : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int NBIT_DEFAULT = 9;
  localparam int LANES        = 3;

  // One unfolded output word: element 0 is sample 3k, element 2 is 3k+2.
  typedef logic [NBIT_DEFAULT-1:0] lane_triple_t [0:LANES-1];

  // Index of the lane currently being serialised (0..LANES-1).
  typedef logic [1:0] lane_idx_t;

  // Lane sequence 0 -> 1 -> 2 -> 0.
  function automatic lane_idx_t next_lane(input lane_idx_t lane);
    if (lane == lane_idx_t'(LANES - 1)) begin
      return '0;
    end
    return lane + 2'd1;
  endfunction

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir3_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fir3_word_fifo
// Purpose  : DEPTH-entry FIFO of packed lane triples. DEPTH need not be a
//            power of two; both pointers wrap explicitly at DEPTH.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset (clears pointers/count)
//            push     - write wr_word this cycle (ignored when full)
//            pop      - discard the head word this cycle (ignored when empty)
//            wr_word  - incoming triple, lane i at [i*NBIT +: NBIT]
//            rd_word  - head triple, same packing
//            count    - number of stored words
//            full     - count == DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module fir3_word_fifo
  import fir_pkg::*;
#(
  parameter int  NBIT   = NBIT_DEFAULT,
  parameter int  DEPTH  = 2,
  localparam int WORD_W = LANES * NBIT,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wr_word,
  output logic [WORD_W-1:0] rd_word,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_word = mem[rd_ptr];

  // Storage is not reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule : fir3_word_fifo
`default_nettype wire

// File: rtl/fir3_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : fir3_unpacker
// Purpose  : Parallel-to-serial unpacker behind the 3-way unfolded FIR.
//            Buffers 3-lane words and emits one sample per clock in order.
// Ports    : CLK    - clock, rising edge
//            RST_n  - asynchronous active-low reset
//            DIN3k  - lane 0 (sample 3k)
//            DIN3k1 - lane 1 (sample 3k+1)
//            DIN3k2 - lane 2 (sample 3k+2)
//            VIN    - input word valid
//            READY  - FIFO can accept a word this cycle
//            DOUT   - registered serial sample
//            VOUT   - registered DOUT valid
//            OVF    - sticky: a word arrived while READY was low
// Revision : 1.0 - initial release
// ============================================================================
module fir3_unpacker
  import fir_pkg::*;
#(
  parameter int  NBIT   = NBIT_DEFAULT,
  parameter int  DEPTH  = 2,
  localparam int WORD_W = LANES * NBIT,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic [NBIT-1:0] DIN3k,
  input  logic [NBIT-1:0] DIN3k1,
  input  logic [NBIT-1:0] DIN3k2,
  input  logic            VIN,
  output logic            READY,
  output logic [NBIT-1:0] DOUT,
  output logic            VOUT,
  output logic            OVF
);

  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] head_word;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              emit;
  lane_idx_t         lane;
  logic [NBIT-1:0]   lane_sample;

  assign wr_word = {DIN3k2, DIN3k1, DIN3k};

  // READY depends only on the registered count, never on a same-cycle pop.
  assign READY = ~fifo_full;
  assign push  = VIN & READY;
  assign emit  = (fifo_count != '0);
  // The head word leaves the FIFO as its last lane is emitted.
  assign pop   = emit && (lane == lane_idx_t'(LANES - 1));

  always_comb begin
    lane_sample = head_word[NBIT-1:0];
    case (lane)
      2'd0:    lane_sample = head_word[0*NBIT +: NBIT];
      2'd1:    lane_sample = head_word[1*NBIT +: NBIT];
      default: lane_sample = head_word[2*NBIT +: NBIT];
    endcase
  end

  fir3_word_fifo #(
    .NBIT  (NBIT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_n),
    .push    (push),
    .pop     (pop),
    .wr_word (wr_word),
    .rd_word (head_word),
    .count   (fifo_count),
    .full    (fifo_full)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      DOUT <= '0;
      VOUT <= 1'b0;
      OVF  <= 1'b0;
      lane <= '0;
    end else begin
      if (VIN && !READY) begin
        OVF <= 1'b1;
      end
      if (emit) begin
        DOUT <= lane_sample;
        VOUT <= 1'b1;
        lane <= next_lane(lane);
      end else begin
        // Idle: DOUT keeps its last sample.
        VOUT <= 1'b0;
      end
    end
  end

endmodule : fir3_unpacker
`default_nettype wire

// File: tb/tb_fir3_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir3_unpacker
// Purpose  : Directed self-checking bench for fir3_unpacker (NBIT=9, DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir3_unpacker;
  import fir_pkg::*;

  logic       CLK;
  logic       RST_n;
  logic [8:0] DIN3k;
  logic [8:0] DIN3k1;
  logic [8:0] DIN3k2;
  logic       VIN;
  logic       READY;
  logic [8:0] DOUT;
  logic       VOUT;
  logic       OVF;

  int checks;
  int failures;

  fir3_unpacker #(
    .NBIT  (9),
    .DEPTH (2)
  ) dut (
    .CLK    (CLK),
    .RST_n  (RST_n),
    .DIN3k  (DIN3k),
    .DIN3k1 (DIN3k1),
    .DIN3k2 (DIN3k2),
    .VIN    (VIN),
    .READY  (READY),
    .DOUT   (DOUT),
    .VOUT   (VOUT),
    .OVF    (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic drive_word(input lane_triple_t w, input logic v);
    DIN3k  = w[0];
    DIN3k1 = w[1];
    DIN3k2 = w[2];
    VIN    = v;
  endtask

  // Tasks start and end 1 time unit after a rising edge.
  task automatic test_reset();
    lane_triple_t w;
    w[0] = 9'h055; w[1] = 9'h0AA; w[2] = 9'h1FF;
    RST_n = 1'b0;
    drive_word(w, 1'b1);
    @(posedge CLK); @(posedge CLK); #1;
    checks++;
    if (DOUT !== 9'h000) begin failures++; $display("FAIL reset_dout: got %h expected %h", DOUT, 9'h000); end
    checks++;
    if (VOUT !== 1'b0) begin failures++; $display("FAIL reset_vout: got %b expected %b", VOUT, 1'b0); end
    checks++;
    if (OVF !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected %b", OVF, 1'b0); end
    checks++;
    if (READY !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected %b", READY, 1'b1); end
    VIN   = 1'b0;
    RST_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (VOUT !== 1'b0) begin failures++; $display("FAIL reset_idle_vout c%0d: got %b expected %b", i, VOUT, 1'b0); end
    end
  endtask

  task automatic test_single_word();
    lane_triple_t w;
    logic [8:0] exp_s [3];
    w[0] = 9'd5; w[1] = 9'h1FD; w[2] = 9'd255;
    exp_s[0] = 9'h005; exp_s[1] = 9'h1FD; exp_s[2] = 9'h0FF;
    drive_word(w, 1'b1);
    @(posedge CLK); #1;
    VIN = 1'b0;
    checks++;
    if (VOUT !== 1'b0) begin failures++; $display("FAIL single_latency_vout: got %b expected %b", VOUT, 1'b0); end
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      checks++;
      if (VOUT !== 1'b1 || DOUT !== exp_s[k]) begin
        failures++;
        $display("FAIL single_lane%0d: got vout=%b dout=%h expected vout=1 dout=%h", k, VOUT, DOUT, exp_s[k]);
      end
    end
    @(posedge CLK); #1;
    checks++;
    if (VOUT !== 1'b0 || DOUT !== 9'h0FF) begin
      failures++;
      $display("FAIL single_idle: got vout=%b dout=%h expected vout=0 dout=%h", VOUT, DOUT, 9'h0FF);
    end
  endtask

  task automatic test_rated_stream();
    lane_triple_t w;
    for (int c = 0; c < 32; c++) begin
      w[0] = 9'(3 * (c / 3));
      w[1] = 9'(3 * (c / 3) + 1);
      w[2] = 9'(3 * (c / 3) + 2);
      drive_word(w, (c % 3 == 0) && (c < 30));
      checks++;
      if (READY !== 1'b1) begin failures++; $display("FAIL rated_ready c%0d: got %b expected %b", c, READY, 1'b1); end
      @(posedge CLK); #1;
      checks++;
      if (c >= 1 && c <= 30) begin
        if (VOUT !== 1'b1 || DOUT !== 9'(c - 1)) begin
          failures++;
          $display("FAIL rated_sample c%0d: got vout=%b dout=%0d expected vout=1 dout=%0d", c, VOUT, DOUT, c - 1);
        end
      end else begin
        if (VOUT !== 1'b0) begin failures++; $display("FAIL rated_idle c%0d: got %b expected %b", c, VOUT, 1'b0); end
      end
    end
    VIN = 1'b0;
    checks++;
    if (OVF !== 1'b0) begin failures++; $display("FAIL rated_ovf: got %b expected %b", OVF, 1'b0); end
  endtask

  task automatic test_burst_overflow();
    lane_triple_t w;
    logic [8:0] exp_s [6];
    logic       exp_ready;
    exp_s[0] = 9'd10; exp_s[1] = 9'd11; exp_s[2] = 9'd12;
    exp_s[3] = 9'd20; exp_s[4] = 9'd21; exp_s[5] = 9'd22;
    for (int j = 0; j < 8; j++) begin
      w[0] = 9'(10 * j + 10); w[1] = 9'(10 * j + 11); w[2] = 9'(10 * j + 12);
      drive_word(w, j < 4);
      exp_ready = !(j == 2 || j == 3);
      checks++;
      if (READY !== exp_ready) begin failures++; $display("FAIL burst_ready j%0d: got %b expected %b", j, READY, exp_ready); end
      @(posedge CLK); #1;
      checks++;
      if (OVF !== (j >= 2)) begin failures++; $display("FAIL burst_ovf j%0d: got %b expected %b", j, OVF, (j >= 2)); end
      checks++;
      if (j >= 1 && j <= 6) begin
        if (VOUT !== 1'b1 || DOUT !== exp_s[j-1]) begin
          failures++;
          $display("FAIL burst_sample j%0d: got vout=%b dout=%0d expected vout=1 dout=%0d", j, VOUT, DOUT, exp_s[j-1]);
        end
      end else begin
        if (VOUT !== 1'b0) begin failures++; $display("FAIL burst_idle j%0d: got %b expected %b", j, VOUT, 1'b0); end
      end
    end
    VIN = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (OVF !== 1'b1) begin failures++; $display("FAIL burst_ovf_sticky: got %b expected %b", OVF, 1'b1); end
  endtask

  task automatic test_reset_mid_word();
    lane_triple_t w;
    w[0] = 9'd7; w[1] = 9'd8; w[2] = 9'd9;
    drive_word(w, 1'b1);
    @(posedge CLK); #1;
    VIN = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++;
    if (VOUT !== 1'b1 || DOUT !== 9'd8) begin
      failures++;
      $display("FAIL midrst_lane1: got vout=%b dout=%0d expected vout=1 dout=8", VOUT, DOUT);
    end
    #1 RST_n = 1'b0;
    #1;
    checks++;
    if (VOUT !== 1'b0 || DOUT !== 9'd0) begin
      failures++;
      $display("FAIL midrst_async: got vout=%b dout=%0d expected vout=0 dout=0", VOUT, DOUT);
    end
    checks++;
    if (OVF !== 1'b0) begin failures++; $display("FAIL midrst_ovf: got %b expected %b", OVF, 1'b0); end
    #3 RST_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (VOUT !== 1'b0) begin failures++; $display("FAIL midrst_residual c%0d: got %b expected %b", i, VOUT, 1'b0); end
    end
  endtask

  task automatic test_back_to_back();
    lane_triple_t w;
    logic [8:0] exp_s [9];
    logic       exp_ready;
    for (int k = 0; k < 9; k++) exp_s[k] = 9'(100 + (k / 3) * 10 + (k % 3));
    for (int j = 0; j < 11; j++) begin
      // A at j=0, B on A's lane-2 emit cycle (j=3), C at j=4.
      w[0] = 9'(100 + (j == 0 ? 0 : (j == 3 ? 10 : 20)));
      w[1] = w[0] + 9'd1;
      w[2] = w[0] + 9'd2;
      drive_word(w, (j == 0) || (j == 3) || (j == 4));
      exp_ready = !(j == 5 || j == 6);
      checks++;
      if (READY !== exp_ready) begin failures++; $display("FAIL b2b_ready j%0d: got %b expected %b", j, READY, exp_ready); end
      @(posedge CLK); #1;
      checks++;
      if (j >= 1 && j <= 9) begin
        if (VOUT !== 1'b1 || DOUT !== exp_s[j-1]) begin
          failures++;
          $display("FAIL b2b_sample j%0d: got vout=%b dout=%0d expected vout=1 dout=%0d", j, VOUT, DOUT, exp_s[j-1]);
        end
      end else begin
        if (VOUT !== 1'b0) begin failures++; $display("FAIL b2b_idle j%0d: got %b expected %b", j, VOUT, 1'b0); end
      end
    end
    VIN = 1'b0;
    checks++;
    if (OVF !== 1'b0) begin failures++; $display("FAIL b2b_ovf: got %b expected %b", OVF, 1'b0); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST_n    = 1'b0;
    VIN      = 1'b0;
    DIN3k    = '0;
    DIN3k1   = '0;
    DIN3k2   = '0;
    test_reset();
    test_single_word();
    test_rated_stream();
    test_burst_overflow();
    test_reset_mid_word();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fir3_unpacker
`default_nettype wire
